// File: rtl/ctrl_pipe_pkg.sv
// Shared definitions for the decode->execute->mem->writeback control pipeline.
// Stage indices and control-word field positions used by decoders and datapath.
package ctrl_pipe_pkg;

   localparam int unsigned STG_E = 0;
   localparam int unsigned STG_M = 1;
   localparam int unsigned STG_W = 2;

   localparam int unsigned CTRL_W      = 13;
   localparam int unsigned F_MEMTOREG  = 0;
   localparam int unsigned F_MEMWRITE  = 1;
   localparam int unsigned F_ALUSRC    = 2;
   localparam int unsigned F_REGDST    = 3;
   localparam int unsigned F_REGWRITE  = 4;
   localparam int unsigned F_ALUCTRL_L = 5;
   localparam int unsigned F_ALUCTRL_W = 5;
   localparam int unsigned F_BAL       = 10;
   localparam int unsigned F_JAL       = 11;
   localparam int unsigned F_JR        = 12;

   // Field view of one control word, MSB first to match the bit positions above
   typedef struct packed {
      logic       jr;
      logic       jal;
      logic       bal;
      logic [4:0] alu_ctrl;
      logic       regwrite;
      logic       regdst;
      logic       alusrc;
      logic       memwrite;
      logic       memtoreg;
   } ctrl_word_t;

endpackage

// File: rtl/ctrl_pipe_if.sv
// Bus bundle between decode/hazard logic (master) and the control pipeline (slave).
interface ctrl_pipe_if #(
   parameter int unsigned CW     = 13,
   parameter int unsigned NSTG   = 3,
   parameter int unsigned SCNT_W = 32
) ();

   logic [CW-1:0]      ctrl_d;
   logic               valid_d;
   logic [NSTG-1:0]    stall_req;
   logic [NSTG-1:0]    flush;
   logic               mc_start;
   logic [NSTG*CW-1:0] ctrl_o;
   logic [NSTG-1:0]    valid_o;
   logic               hold_d;
   logic               mc_busy;
   logic               mc_done;
   logic [SCNT_W-1:0]  stall_cnt;

   modport master (
      output ctrl_d, valid_d, stall_req, flush, mc_start,
      input  ctrl_o, valid_o, hold_d, mc_busy, mc_done, stall_cnt
   );

   modport slave (
      input  ctrl_d, valid_d, stall_req, flush, mc_start,
      output ctrl_o, valid_o, hold_d, mc_busy, mc_done, stall_cnt
   );

endinterface

// File: rtl/ctrl_stage_reg.sv
// One pipeline stage: control word plus valid, with flush > hold > bubble > load priority.
module ctrl_stage_reg #(
   parameter int unsigned CW = 13
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          flush,
   input  logic          hold,
   input  logic          bubble,
   input  logic [CW-1:0] in_word,
   input  logic          in_valid,
   output logic [CW-1:0] out_word,
   output logic          out_valid
);

   logic [CW-1:0] word_q, word_d;
   logic          vld_q, vld_d;

   // An invalid stage never carries a non-zero word
   always_comb begin
      word_d = word_q;
      vld_d  = vld_q;
      if (flush || (!hold && bubble)) begin
         word_d = '0;
         vld_d  = 1'b0;
      end else if (!hold) begin
         word_d = in_valid ? in_word : '0;
         vld_d  = in_valid;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         word_q <= '0;
         vld_q  <= 1'b0;
      end else begin
         word_q <= word_d;
         vld_q  <= vld_d;
      end
   end

   assign out_word  = word_q;
   assign out_valid = vld_q;

endmodule

// File: rtl/ctrl_pipe.sv
// Control-word pipeline with per-stage stall/flush, bubble insertion,
// a multi-cycle-op interlock on the first stage and a saturating stall counter.
module ctrl_pipe
   import ctrl_pipe_pkg::*;
#(
   parameter int unsigned CW        = 13,
   parameter int unsigned NSTG      = 3,
   parameter int unsigned MC_CYCLES = 32,
   parameter int unsigned SCNT_W    = 32
) (
   input logic          clk,
   input logic          rst,
   ctrl_pipe_if.slave   bus
);

   localparam int unsigned MCW = $clog2(MC_CYCLES + 1);

   logic [NSTG-1:0]    s_eff_c;
   logic [CW-1:0]      word_s [NSTG];
   logic [NSTG-1:0]    vld_s;
   logic [NSTG*CW-1:0] ctrl_flat;

   logic [MCW-1:0]     mc_cnt_q, mc_cnt_d;
   logic               mc_busy_q, mc_busy_d;
   logic               mc_done_q, mc_done_d;
   logic [SCNT_W-1:0]  stall_cnt_q, stall_cnt_d;

   // A stage stalls if it or any later stage stalls; the interlock also stalls stage E
   always_comb begin
      s_eff_c = '0;
      for (int k = 0; k < NSTG; k++) begin
         s_eff_c[k] = |(bus.stall_req >> k);
      end
      s_eff_c[STG_E] = s_eff_c[STG_E] | mc_busy_q;
   end

   for (genvar k = 0; k < NSTG; k++) begin : g_stage
      logic [CW-1:0] in_word;
      logic          in_valid;
      logic          bubble;

      if (k == 0) begin : g_first
         assign in_word  = bus.ctrl_d;
         assign in_valid = bus.valid_d;
         assign bubble   = 1'b0;
      end else begin : g_rest
         assign in_word  = word_s[k-1];
         assign in_valid = vld_s[k-1];
         assign bubble   = s_eff_c[k-1];
      end

      ctrl_stage_reg #(.CW(CW)) u_stage (
         .clk       (clk),
         .rst       (rst),
         .flush     (bus.flush[k]),
         .hold      (s_eff_c[k]),
         .bubble    (bubble),
         .in_word   (in_word),
         .in_valid  (in_valid),
         .out_word  (word_s[k]),
         .out_valid (vld_s[k])
      );
   end

   always_comb begin
      ctrl_flat = '0;
      for (int k = 0; k < NSTG; k++) begin
         ctrl_flat[k*CW +: CW] = word_s[k];
      end
   end

   // Interlock counter: flush of stage E cancels a running op without a done pulse
   always_comb begin
      mc_cnt_d  = mc_cnt_q;
      mc_done_d = 1'b0;
      if (bus.flush[STG_E]) begin
         mc_cnt_d = '0;
      end else if (mc_cnt_q != '0) begin
         mc_cnt_d  = mc_cnt_q - MCW'(1);
         mc_done_d = (mc_cnt_q == MCW'(1));
      end else if (bus.mc_start && vld_s[STG_E]) begin
         mc_cnt_d = MCW'(MC_CYCLES);
      end
      mc_busy_d = (mc_cnt_d != '0);
   end

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (s_eff_c[STG_E] && (stall_cnt_q != '1)) begin
         stall_cnt_d = stall_cnt_q + SCNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mc_cnt_q    <= '0;
         mc_busy_q   <= 1'b0;
         mc_done_q   <= 1'b0;
         stall_cnt_q <= '0;
      end else begin
         mc_cnt_q    <= mc_cnt_d;
         mc_busy_q   <= mc_busy_d;
         mc_done_q   <= mc_done_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign bus.ctrl_o    = ctrl_flat;
   assign bus.valid_o   = vld_s;
   assign bus.hold_d    = s_eff_c[STG_E];
   assign bus.mc_busy   = mc_busy_q;
   assign bus.mc_done   = mc_done_q;
   assign bus.stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_ctrl_pipe.sv
// Directed bench for ctrl_pipe: vector table for streaming/stall/flush, hand sequences
// for the multi-cycle interlock, stall-counter saturation and mid-run reset.
module tb_ctrl_pipe;

   localparam int unsigned CW   = 13;
   localparam int unsigned NSTG = 3;
   localparam int unsigned MCC  = 4;
   localparam int unsigned SW   = 4;

   typedef struct {
      logic [CW-1:0] ctrl;
      logic          vld;
      logic [2:0]    stall;
      logic [2:0]    flush;
      logic          e_hold;
      logic [CW-1:0] e_w0;
      logic [CW-1:0] e_w1;
      logic [CW-1:0] e_w2;
      logic [2:0]    e_valid;
      logic [SW-1:0] e_cnt;
   } vec_t;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;
   int   done_pulses;
   vec_t vecs [12];

   ctrl_pipe_if #(.CW(CW), .NSTG(NSTG), .SCNT_W(SW)) bus ();

   ctrl_pipe #(.CW(CW), .NSTG(NSTG), .MC_CYCLES(MCC), .SCNT_W(SW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   function automatic vec_t mk(input logic [CW-1:0] c, input logic v, input logic [2:0] s,
                               input logic [2:0] f, input logic eh, input logic [CW-1:0] w0,
                               input logic [CW-1:0] w1, input logic [CW-1:0] w2,
                               input logic [2:0] ev, input logic [SW-1:0] ec);
      vec_t r;
      r.ctrl = c; r.vld = v; r.stall = s; r.flush = f; r.e_hold = eh;
      r.e_w0 = w0; r.e_w1 = w1; r.e_w2 = w2; r.e_valid = ev; r.e_cnt = ec;
      return r;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic [CW-1:0] c, input logic v, input logic [2:0] s,
                        input logic [2:0] f, input logic m);
      bus.ctrl_d    = c;
      bus.valid_d   = v;
      bus.stall_req = s;
      bus.flush     = f;
      bus.mc_start  = m;
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      drive('0, 1'b0, 3'b000, 3'b000, 1'b0);
      tick();
      rst = 1'b0;
   endtask

   task automatic chk_regs(input string tag, input logic [CW-1:0] w0, input logic [CW-1:0] w1,
                           input logic [CW-1:0] w2, input logic [2:0] v);
      chk({tag, "_ctrl"}, 64'(bus.ctrl_o), 64'({w2, w1, w0}));
      chk({tag, "_valid"}, 64'(bus.valid_o), 64'(v));
   endtask

   initial begin
      rst = 1'b1;
      drive('0, 1'b0, 3'b000, 3'b000, 1'b0);
      tick();
      tick();
      chk_regs("reset", '0, '0, '0, 3'b000);
      chk("reset_cnt", 64'(bus.stall_cnt), 64'(0));
      chk("reset_busy", 64'(bus.mc_busy), 64'(0));
      chk("reset_done", 64'(bus.mc_done), 64'(0));
      chk("reset_hold", 64'(bus.hold_d), 64'(0));
      rst = 1'b0;

      // Streaming, stall of stage M with bubble into W, flush vs stall on E, invalid input
      vecs[0]  = mk(13'h001, 1'b1, 3'b000, 3'b000, 1'b0, 13'h001, 13'h000, 13'h000, 3'b001, 4'd0);
      vecs[1]  = mk(13'h002, 1'b1, 3'b000, 3'b000, 1'b0, 13'h002, 13'h001, 13'h000, 3'b011, 4'd0);
      vecs[2]  = mk(13'h003, 1'b1, 3'b000, 3'b000, 1'b0, 13'h003, 13'h002, 13'h001, 3'b111, 4'd0);
      vecs[3]  = mk(13'h004, 1'b1, 3'b000, 3'b000, 1'b0, 13'h004, 13'h003, 13'h002, 3'b111, 4'd0);
      vecs[4]  = mk(13'h005, 1'b1, 3'b010, 3'b000, 1'b1, 13'h004, 13'h003, 13'h000, 3'b011, 4'd1);
      vecs[5]  = mk(13'h005, 1'b1, 3'b010, 3'b000, 1'b1, 13'h004, 13'h003, 13'h000, 3'b011, 4'd2);
      vecs[6]  = mk(13'h005, 1'b1, 3'b000, 3'b000, 1'b0, 13'h005, 13'h004, 13'h003, 3'b111, 4'd2);
      vecs[7]  = mk(13'h006, 1'b1, 3'b001, 3'b001, 1'b1, 13'h000, 13'h000, 13'h004, 3'b100, 4'd3);
      vecs[8]  = mk(13'h006, 1'b1, 3'b001, 3'b000, 1'b1, 13'h000, 13'h000, 13'h000, 3'b000, 4'd4);
      vecs[9]  = mk(13'h007, 1'b1, 3'b000, 3'b000, 1'b0, 13'h007, 13'h000, 13'h000, 3'b001, 4'd4);
      vecs[10] = mk(13'h1FFF, 1'b0, 3'b000, 3'b000, 1'b0, 13'h000, 13'h007, 13'h000, 3'b010, 4'd4);
      vecs[11] = mk(13'h00A, 1'b1, 3'b000, 3'b010, 1'b0, 13'h00A, 13'h000, 13'h007, 3'b101, 4'd4);

      for (int i = 0; i < 12; i++) begin
         drive(vecs[i].ctrl, vecs[i].vld, vecs[i].stall, vecs[i].flush, 1'b0);
         chk($sformatf("v%0d_hold", i), 64'(bus.hold_d), 64'(vecs[i].e_hold));
         tick();
         chk_regs($sformatf("v%0d", i), vecs[i].e_w0, vecs[i].e_w1, vecs[i].e_w2, vecs[i].e_valid);
         chk($sformatf("v%0d_cnt", i), 64'(bus.stall_cnt), 64'(vecs[i].e_cnt));
         chk($sformatf("v%0d_busy", i), 64'(bus.mc_busy), 64'(0));
      end

      // Multi-cycle op: accepted word moves on, the next word is held while busy
      do_reset();
      drive(13'h011, 1'b1, 3'b000, 3'b000, 1'b0);
      tick();
      drive(13'h012, 1'b1, 3'b000, 3'b000, 1'b1);
      chk("mc_accept_hold", 64'(bus.hold_d), 64'(0));
      tick();
      chk("mc_busy_start", 64'(bus.mc_busy), 64'(1));
      chk_regs("mc_accept", 13'h012, 13'h011, 13'h000, 3'b011);
      drive(13'h013, 1'b1, 3'b000, 3'b000, 1'b0);
      done_pulses = 0;
      for (int i = 0; i < int'(MCC); i++) begin
         chk($sformatf("mc_hold%0d", i), 64'(bus.hold_d), 64'(1));
         chk($sformatf("mc_busy%0d", i), 64'(bus.mc_busy), 64'(1));
         if (bus.mc_done) done_pulses++;
         tick();
         chk($sformatf("mc_s0_%0d", i), 64'(bus.ctrl_o[CW-1:0]), 64'(13'h012));
      end
      chk("mc_busy_end", 64'(bus.mc_busy), 64'(0));
      chk("mc_done_pulse", 64'(bus.mc_done), 64'(1));
      chk("mc_stall_cnt", 64'(bus.stall_cnt), 64'(4));
      chk("mc_release_hold", 64'(bus.hold_d), 64'(0));
      tick();
      chk("mc_done_clear", 64'(bus.mc_done), 64'(0));
      chk("mc_done_count", 64'(done_pulses), 64'(0));
      chk_regs("mc_advance", 13'h013, 13'h012, 13'h000, 3'b011);

      // Flush of stage E during a running op cancels it without a done pulse
      do_reset();
      drive(13'h021, 1'b1, 3'b000, 3'b000, 1'b0);
      tick();
      drive(13'h022, 1'b1, 3'b000, 3'b000, 1'b1);
      tick();
      drive(13'h023, 1'b1, 3'b000, 3'b000, 1'b0);
      tick();
      chk("mcf_busy1", 64'(bus.mc_busy), 64'(1));
      drive(13'h023, 1'b1, 3'b000, 3'b001, 1'b0);
      tick();
      chk("mcf_busy_drop", 64'(bus.mc_busy), 64'(0));
      chk("mcf_no_done", 64'(bus.mc_done), 64'(0));
      chk("mcf_s0_valid", 64'(bus.valid_o[0]), 64'(0));
      chk("mcf_s0_word", 64'(bus.ctrl_o[CW-1:0]), 64'(0));
      drive('0, 1'b0, 3'b000, 3'b000, 1'b0);
      tick();
      chk("mcf_no_done2", 64'(bus.mc_done), 64'(0));

      // Stall counter saturates, then reset mid-run clears everything
      do_reset();
      drive(13'h031, 1'b1, 3'b000, 3'b000, 1'b0); tick();
      drive(13'h032, 1'b1, 3'b000, 3'b000, 1'b0); tick();
      drive(13'h033, 1'b1, 3'b000, 3'b000, 1'b0); tick();
      drive(13'h034, 1'b1, 3'b100, 3'b000, 1'b0);
      for (int i = 0; i < 20; i++) begin
         if (i == 0) chk("sat_hold", 64'(bus.hold_d), 64'(1));
         tick();
         if (i == 14) chk("sat_cnt15", 64'(bus.stall_cnt), 64'(15));
      end
      chk("sat_cnt_final", 64'(bus.stall_cnt), 64'(15));
      chk_regs("sat_held", 13'h033, 13'h032, 13'h031, 3'b111);
      rst = 1'b1;
      drive(13'h035, 1'b1, 3'b100, 3'b000, 1'b1);
      tick();
      chk_regs("midrst", '0, '0, '0, 3'b000);
      chk("midrst_cnt", 64'(bus.stall_cnt), 64'(0));
      chk("midrst_busy", 64'(bus.mc_busy), 64'(0));
      chk("midrst_done", 64'(bus.mc_done), 64'(0));
      rst = 1'b0;
      drive('0, 1'b0, 3'b000, 3'b000, 1'b0);
      chk("midrst_hold", 64'(bus.hold_d), 64'(0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
